// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory load controller:
// FSM state codes, the NOP instruction word and default memory geometry.
package imem_pkg;

    // Default instruction memory geometry (words / word-address bits).
    localparam int IMEM_DEPTH = 32;
    localparam int IMEM_AW    = 5;

    // addi x0,x0,0 -- returned whenever a fetch cannot return real code.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Controller state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

endpackage : imem_pkg

// File: rtl/imem_fetch_port.sv
// Fetch-side read port: turns a byte PC into a word index, checks
// alignment/range, substitutes NOP for faulted or unloaded words and
// registers the result for the IF stage.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int          DEPTH = IMEM_DEPTH,
    parameter int          AW    = IMEM_AW,
    parameter logic [31:0] NOP   = NOP_INSN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_en,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    input  logic [AW:0]   word_count,
    input  logic [31:0]   mem_rdata,
    output logic [AW-1:0] mem_raddr,
    output logic [31:0]   fetch_rdata,
    output logic          fetch_valid,
    output logic          fetch_fault
);

    logic        misaligned;
    logic        out_of_range;
    logic        fault_c;
    logic        loaded_c;
    logic [31:0] rdata_c;

    logic [31:0] fetch_rdata_reg;
    logic        fetch_valid_reg;
    logic        fetch_fault_reg;

    // Upper PC bits are dropped here; they only matter for the range check.
    assign mem_raddr = fetch_addr[AW+1:2];

    // Decode the request: fault on misaligned or out-of-memory PCs, NOP past the loaded image.
    always_comb begin
        misaligned   = |fetch_addr[1:0];
        out_of_range = fetch_addr >= 32'(DEPTH * 4);
        fault_c      = misaligned | out_of_range;
        loaded_c     = {1'b0, mem_raddr} < word_count;
        rdata_c      = (!fault_c && loaded_c) ? mem_rdata : NOP;
    end

    // Output register: one-cycle fetch latency, cleared when no request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_rdata_reg <= '0;
            fetch_valid_reg <= 1'b0;
            fetch_fault_reg <= 1'b0;
        end else if (run_en && fetch_req) begin
            fetch_rdata_reg <= rdata_c;
            fetch_valid_reg <= 1'b1;
            fetch_fault_reg <= fault_c;
        end else begin
            fetch_rdata_reg <= '0;
            fetch_valid_reg <= 1'b0;
            fetch_fault_reg <= 1'b0;
        end
    end

    assign fetch_rdata = fetch_rdata_reg;
    assign fetch_valid = fetch_valid_reg;
    assign fetch_fault = fetch_fault_reg;

endmodule : imem_fetch_port

// File: rtl/imem_load_ctrl.sv
// Instruction memory owner: accepts a program from a valid/ready loader,
// writes it word by word, stalls the CPU until the image is complete and
// then serves fetches through imem_fetch_port.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH = IMEM_DEPTH,
    parameter int          AW    = IMEM_AW,
    parameter logic [31:0] NOP   = NOP_INSN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   word_count,
    output logic          cpu_stall,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   fetch_rdata,
    output logic          fetch_valid,
    output logic          fetch_fault,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata
);

    logic [2:0]    state_reg, state_next;
    logic [AW-1:0] wptr_reg;
    logic [AW:0]   word_count_reg;
    logic          load_err_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_waddr_reg;
    logic [31:0]   mem_wdata_reg;
    logic          hs;
    logic          run_en;

    assign ld_ready  = (state_reg == ST_LOAD);
    assign hs        = ld_valid & ld_ready;
    assign cpu_stall = (state_reg != ST_RUN);
    assign load_done = (state_reg == ST_FLUSH);
    // A restart in the same cycle as a fetch wins over the fetch.
    assign run_en    = (state_reg == ST_RUN) & ~ld_start;

    // Next-state logic; ld_start restarts the load from any state.
    always_comb begin
        state_next = state_reg;
        if (ld_start) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_IDLE;
                ST_LOAD: begin
                    if (hs) begin
                        if (ld_last)
                            state_next = ST_FLUSH;
                        else if (wptr_reg == AW'(DEPTH - 1))
                            state_next = ST_ERR;
                    end
                end
                ST_FLUSH: state_next = ST_RUN;
                ST_RUN:   state_next = ST_RUN;
                ST_ERR:   state_next = ST_ERR;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // State, write pointer, word count and the registered memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wptr_reg       <= '0;
            word_count_reg <= '0;
            load_err_reg   <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_waddr_reg  <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            // A word handshaken in the same cycle as ld_start is dropped.
            mem_we_reg <= hs & ~ld_start;
            if (ld_start) begin
                wptr_reg       <= '0;
                word_count_reg <= '0;
                load_err_reg   <= 1'b0;
            end else begin
                if (hs) begin
                    mem_waddr_reg <= wptr_reg;
                    mem_wdata_reg <= ld_data;
                    wptr_reg      <= wptr_reg + 1'b1;
                    if (word_count_reg < (AW+1)'(DEPTH))
                        word_count_reg <= word_count_reg + 1'b1;
                end
                if (state_next == ST_ERR)
                    load_err_reg <= 1'b1;
            end
        end
    end

    assign load_err   = load_err_reg;
    assign word_count = word_count_reg;
    assign mem_we     = mem_we_reg;
    assign mem_waddr  = mem_waddr_reg;
    assign mem_wdata  = mem_wdata_reg;

    imem_fetch_port #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .NOP   (NOP)
    ) u_fetch (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .word_count  (word_count_reg),
        .mem_rdata   (mem_rdata),
        .mem_raddr   (mem_raddr),
        .fetch_rdata (fetch_rdata),
        .fetch_valid (fetch_valid),
        .fetch_fault (fetch_fault)
    );

endmodule : imem_load_ctrl

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: expected memory writes and fetch
// results are queued as stimulus is driven and checked when the DUT emits them.
module tb_imem_load_ctrl;

    localparam int          DEPTH = 32;
    localparam int          AW    = 5;
    localparam logic [31:0] NOPW  = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_start;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;
    logic          cpu_stall;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic [31:0]   fetch_rdata;
    logic          fetch_valid;
    logic          fetch_fault;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [36:0] wq[$];   // {waddr, wdata}
    logic [32:0] fq[$];   // {fault, rdata}

    logic [31:0] model_mem [0:DEPTH-1];
    int          model_count;
    int          wexp_addr;

    // External memory with asynchronous read
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    always #5 clk = ~clk;

    imem_load_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .load_done   (load_done),
        .load_err    (load_err),
        .word_count  (word_count),
        .cpu_stall   (cpu_stall),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_rdata (fetch_rdata),
        .fetch_valid (fetch_valid),
        .fetch_fault (fetch_fault),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] exp_fetch(input logic [31:0] a);
        logic [4:0] idx;
        idx = a[6:2];
        if (a[1:0] != 2'b00 || a >= 32'd128) return {1'b1, NOPW};
        if (int'(a >> 2) < model_count)      return {1'b0, model_mem[idx]};
        return {1'b0, NOPW};
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        wq.push_back({5'(wexp_addr), d});
        model_mem[wexp_addr] = d;
        wexp_addr++;
        model_count = wexp_addr;
        @(negedge clk);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        fq.push_back(exp_fetch(a));
        @(negedge clk);
    endtask

    // Scoreboard monitor: pops expectations as writes and fetch results appear.
    always @(negedge clk) begin
        logic [36:0] we;
        logic [32:0] fe;
        if (mem_we) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                we = wq.pop_front();
                $display("WRITE addr %0d data %08h", mem_waddr, mem_wdata);
                chk("wr_addr", 64'(mem_waddr), 64'(we[36:32]));
                chk("wr_data", 64'(mem_wdata), 64'(we[31:0]));
            end
        end
        if (fetch_valid) begin
            if (fq.size() == 0) begin
                chk("fetch_unexpected", 1, 0);
            end else begin
                fe = fq.pop_front();
                $display("FETCH data %08h fault %0d", fetch_rdata, fetch_fault);
                chk("fetch_rdata", 64'(fetch_rdata), 64'(fe[31:0]));
                chk("fetch_fault", 64'(fetch_fault), 64'(fe[32]));
            end
        end
    end

    initial begin
        logic [31:0] fa [0:5];
        fa[0] = 32'h8; fa[1] = 32'hC; fa[2] = 32'h6;
        fa[3] = 32'h80; fa[4] = 32'h0; fa[5] = 32'h4;

        rst = 1'b1; ld_start = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
        fetch_req = 0; fetch_addr = 0;
        model_count = 0; wexp_addr = 0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_stall", cpu_stall, 1);
        chk("rst_ready", ld_ready, 0);
        chk("rst_count", word_count, 0);
        chk("rst_err", load_err, 0);
        chk("rst_done", load_done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_fvalid", fetch_valid, 0);
        rst = 1'b0;

        // Three-word program
        ld_start = 1; @(negedge clk); ld_start = 0;
        chk("load_ready", ld_ready, 1);
        wexp_addr = 0; model_count = 0;
        send_word(32'h0050_0093, 0);
        send_word(32'h0010_0113, 0);
        send_word(32'h0020_81B3, 1);
        ld_valid = 0; ld_last = 0;
        chk("flush_done", load_done, 1);
        chk("flush_stall", cpu_stall, 1);
        chk("flush_ready", ld_ready, 0);
        chk("flush_count", word_count, 3);
        @(negedge clk);
        chk("run_stall", cpu_stall, 0);
        chk("run_done", load_done, 0);
        chk("run_count", word_count, 3);

        // Fetches: loaded, unloaded, misaligned, out of range
        for (int i = 0; i < 6; i++) do_fetch(fa[i]);
        fetch_req = 0;
        fetch_addr = 32'h88; #1;
        chk("raddr_low", mem_raddr, 2);
        fetch_addr = 32'hFFFF_FF8C; #1;
        chk("raddr_wrap", mem_raddr, 3);
        @(negedge clk);
        chk("idle_fvalid", fetch_valid, 0);

        // ld_start wins over a fetch in RUN
        ld_start = 1; fetch_req = 1; fetch_addr = 0;
        @(negedge clk);
        ld_start = 0; fetch_req = 0;
        chk("restart_fvalid", fetch_valid, 0);
        chk("restart_stall", cpu_stall, 1);
        chk("restart_ready", ld_ready, 1);
        chk("restart_count", word_count, 0);
        wexp_addr = 0; model_count = 0;

        // Overflow: 32 words without ld_last
        for (int i = 0; i < DEPTH; i++) send_word(32'hA500_0000 | 32'(i), 0);
        chk("ovf_err", load_err, 1);
        chk("ovf_stall", cpu_stall, 1);
        chk("ovf_ready", ld_ready, 0);
        chk("ovf_count", word_count, DEPTH);
        @(negedge clk);   // ld_valid still high: must be ignored in ERR
        chk("err_ready", ld_ready, 0);
        chk("err_sticky", load_err, 1);
        ld_valid = 0;
        ld_start = 1; @(negedge clk); ld_start = 0;
        chk("clr_err", load_err, 0);
        chk("clr_count", word_count, 0);
        chk("clr_ready", ld_ready, 1);

        // Handshake coincident with ld_start is dropped
        ld_start = 1; ld_valid = 1; ld_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ld_start = 0; ld_valid = 0;
        chk("drop_we", mem_we, 0);
        chk("drop_count", word_count, 0);
        wexp_addr = 0; model_count = 0;

        // Short reload, then fetch across the loaded boundary
        send_word(32'h0000_0011, 0);
        send_word(32'h0000_0022, 1);
        ld_valid = 0; ld_last = 0;
        @(negedge clk);
        chk("reload_stall", cpu_stall, 0);
        do_fetch(32'h4);
        do_fetch(32'h8);
        fetch_req = 0;

        // Reset during a loader handshake
        ld_start = 1; @(negedge clk); ld_start = 0;
        wexp_addr = 0; model_count = 0;
        send_word(32'h0000_0033, 0);
        rst = 1; ld_valid = 1; ld_data = 32'h0000_0044;
        @(negedge clk);
        rst = 0; ld_valid = 0;
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_stall", cpu_stall, 1);
        chk("rstmid_count", word_count, 0);
        chk("rstmid_ready", ld_ready, 0);
        @(negedge clk);
        chk("rstmid_idle", ld_ready, 0);

        chk("wq_drained", 64'(wq.size()), 0);
        chk("fq_drained", 64'(fq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imem_load_ctrl
